// File: rtl/lsu_ctrl_pkg.sv
// Shared field indices, size codes and sequencer state encodings for the
// MEM-stage load/store unit.
package lsu_ctrl_pkg;

    localparam int LD_ST_INFO_WIDTH = 5;
    localparam int LS_LOAD          = 0;
    localparam int LS_STORE         = 1;
    localparam int LS_SIZE_LSB      = 2;
    localparam int LS_SIZE_MSB      = 3;
    localparam int LS_UNSIGNED      = 4;

    typedef enum logic [1:0] {
        SZ_B  = 2'b00,
        SZ_H  = 2'b01,
        SZ_W  = 2'b10,
        SZ_W2 = 2'b11
    } ls_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE,
        ST_DRAIN
    } lsu_state_e;

    // Size code 11 behaves exactly like a word access.
    function automatic logic is_word(ls_size_e size);
        return (size == SZ_W) || (size == SZ_W2);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-bus port of the load/store unit: request handshake, write payload and
// single-beat response.
interface lsu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] addr;
    logic            wen;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, addr, wen, wstrb, wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, addr, wen, wstrb, wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: misalignment detect, store lane replication
// and strobes, and load byte/half extraction with extension.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  ls_size_e        req_size,
    input  logic [1:0]      req_off,
    input  logic [XLEN-1:0] st_data,
    output logic            mis,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    input  ls_size_e        ld_size,
    input  logic [1:0]      ld_off,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] rsp_data,
    output logic [XLEN-1:0] ld_data
);
    logic [XLEN-1:0] shifted;

    assign mis = ((req_size == SZ_H) && req_off[0]) ||
                 (is_word(req_size) && (req_off != 2'b00));

    always_comb begin
        wstrb = 4'b1111;
        case (req_size)
            SZ_B:    wstrb = 4'b0001 << req_off;
            SZ_H:    wstrb = 4'b0011 << {req_off[1], 1'b0};
            default: wstrb = 4'b1111;
        endcase
    end

    // Narrow stores replicate their data so every lane holds the right byte.
    for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_lane
        assign wdata[8*gi +: 8] = (req_size == SZ_B) ? st_data[7:0] :
                                  (req_size == SZ_H) ? st_data[8*(gi%2) +: 8] :
                                                       st_data[8*gi +: 8];
    end

    assign shifted = rsp_data >> {ld_off, 3'b000};

    always_comb begin
        ld_data = rsp_data;
        case (ld_size)
            SZ_B:    ld_data = {{(XLEN-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{(XLEN-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_data = rsp_data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: issues one data-bus transaction per access,
// stalls the stage until it retires and presents the aligned load result.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_flush_i,
    input  logic                        MEM_valid_i,
    input  logic [LD_ST_INFO_WIDTH-1:0] MEM_ld_st_info_i,
    input  logic [XLEN-1:0]             MEM_alu_res_i,
    input  logic [XLEN-1:0]             MEM_rs2_rdata_i,
    input  logic                        WB_ready_i,
    output logic                        lsu_run_o,
    output logic [XLEN-1:0]             lsu_rdata_o,
    output logic                        lsu_ld_misalign_o,
    output logic                        lsu_st_misalign_o,
    output logic                        lsu_bus_err_o,
    lsu_ctrl_if.master                  dbus
);
    lsu_state_e      state_reg, state_next;
    logic [XLEN-1:0] addr_reg, wdata_reg, rdata_reg;
    logic [3:0]      wstrb_reg;
    logic            wen_reg, err_reg, ld_uns_reg;
    ls_size_e        ld_size_reg;
    logic [1:0]      ld_off_reg;

    logic            is_load, is_store, mis, access, capture_req, capture_rsp;
    ls_size_e        req_size;
    logic [3:0]      req_wstrb;
    logic [XLEN-1:0] req_addr, req_wdata, ld_data;

    assign is_load  = MEM_ld_st_info_i[LS_LOAD];
    assign is_store = MEM_ld_st_info_i[LS_STORE];
    assign req_size = ls_size_e'(MEM_ld_st_info_i[LS_SIZE_MSB:LS_SIZE_LSB]);
    assign req_addr = {MEM_alu_res_i[XLEN-1:2], 2'b00};

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_size    (req_size),
        .req_off     (MEM_alu_res_i[1:0]),
        .st_data     (MEM_rs2_rdata_i),
        .mis         (mis),
        .wstrb       (req_wstrb),
        .wdata       (req_wdata),
        .ld_size     (ld_size_reg),
        .ld_off      (ld_off_reg),
        .ld_unsigned (ld_uns_reg),
        .rsp_data    (rdata_reg),
        .ld_data     (ld_data)
    );

    assign access            = MEM_valid_i & (is_load | is_store) & ~mis & ~mem_flush_i;
    assign lsu_ld_misalign_o = MEM_valid_i & is_load & mis;
    assign lsu_st_misalign_o = MEM_valid_i & is_store & mis;

    // In IDLE the request comes straight from the MEM register; once offered
    // it is replayed from the captured copy so upstream changes cannot leak.
    assign dbus.addr  = (state_reg == ST_IDLE) ? req_addr  : addr_reg;
    assign dbus.wen   = (state_reg == ST_IDLE) ? is_store  : wen_reg;
    assign dbus.wstrb = (state_reg == ST_IDLE) ? req_wstrb : wstrb_reg;
    assign dbus.wdata = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            wen_reg     <= 1'b0;
            ld_size_reg <= SZ_B;
            ld_off_reg  <= 2'b00;
            ld_uns_reg  <= 1'b0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture_req) begin
                addr_reg    <= req_addr;
                wdata_reg   <= req_wdata;
                wstrb_reg   <= req_wstrb;
                wen_reg     <= is_store;
                ld_size_reg <= req_size;
                ld_off_reg  <= MEM_alu_res_i[1:0];
                ld_uns_reg  <= MEM_ld_st_info_i[LS_UNSIGNED];
            end
            if (capture_rsp) begin
                rdata_reg <= dbus.rsp_rdata;
                err_reg   <= dbus.rsp_err;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        dbus.req_valid = 1'b0;
        lsu_run_o      = 1'b1;
        lsu_rdata_o    = '0;
        lsu_bus_err_o  = 1'b0;
        capture_req    = 1'b0;
        capture_rsp    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                dbus.req_valid = access;
                lsu_run_o      = ~access;
                capture_req    = access;
                if (access)
                    state_next = dbus.req_ready ? ST_RSP : ST_REQ;
            end
            ST_REQ: begin
                dbus.req_valid = 1'b1;
                lsu_run_o      = 1'b0;
                // Once accepted the access must finish on the bus even if flushed.
                if (dbus.req_ready)
                    state_next = mem_flush_i ? ST_DRAIN : ST_RSP;
                else if (mem_flush_i)
                    state_next = ST_IDLE;
            end
            ST_RSP: begin
                lsu_run_o = 1'b0;
                if (dbus.rsp_valid) begin
                    capture_rsp = 1'b1;
                    state_next  = mem_flush_i ? ST_IDLE : ST_DONE;
                end else if (mem_flush_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                lsu_rdata_o   = ld_data;
                lsu_bus_err_o = err_reg;
                if (WB_ready_i || mem_flush_i)
                    state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                lsu_run_o = 1'b0;
                if (dbus.rsp_valid)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios with literal expectations, then
// randomized MEM/bus traffic checked every cycle against a transaction model.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic [4:0]  info = '0;
    logic [31:0] alu = '0;
    logic [31:0] rs2 = '0;
    logic        wb_ready = 1'b0;
    logic        run;
    logic [31:0] rdata;
    logic        ld_mis, st_mis, bus_err;

    lsu_ctrl_if #(.XLEN(32)) dbus ();

    lsu_ctrl #(.XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_flush_i       (mem_flush),
        .MEM_valid_i       (mem_valid),
        .MEM_ld_st_info_i  (info),
        .MEM_alu_res_i     (alu),
        .MEM_rs2_rdata_i   (rs2),
        .WB_ready_i        (wb_ready),
        .lsu_run_o         (run),
        .lsu_rdata_o       (rdata),
        .lsu_ld_misalign_o (ld_mis),
        .lsu_st_misalign_o (st_mis),
        .lsu_bus_err_o     (bus_err),
        .dbus              (dbus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_pend, m_out, m_keep, m_res;
    logic [31:0] p_addr, p_wdata, r_data;
    logic [3:0]  p_wstrb;
    bit          p_wen, p_uns, r_err;
    int          p_size, p_off;

    function automatic logic [31:0] m_extract(logic [31:0] d, int size, int off, bit uns);
        logic [31:0] v;
        if (size == 0) begin
            v = (d >> (8 * off)) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (d >> (8 * off)) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    always @(negedge clk) begin : compare
        int          sz, off;
        bit          ld, st, mis, acc, e_req, e_run, e_err, e_wen;
        logic [31:0] e_rdata, e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        ld  = info[0];
        st  = info[1];
        sz  = (info[3:2] == 2'd3) ? 2 : int'(info[3:2]);
        off = int'(alu[1:0]);
        mis = (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
        acc = mem_valid && (ld || st) && !mis && !mem_flush;
        if (rst) begin
            m_pend = 0; m_out = 0; m_keep = 0; m_res = 0;
        end else begin
            e_req = 0; e_run = 1; e_err = 0; e_rdata = 0;
            e_addr = p_addr; e_wen = p_wen; e_wstrb = p_wstrb; e_wdata = p_wdata;
            if (m_res) begin
                e_rdata = m_extract(r_data, p_size, p_off, p_uns);
                e_err   = r_err;
            end else if (m_out) begin
                e_run = 0;
            end else if (m_pend) begin
                e_req = 1; e_run = 0;
            end else begin
                e_req   = acc;
                e_run   = !acc;
                e_addr  = alu & 32'hFFFF_FFFC;
                e_wen   = st;
                e_wstrb = (sz == 0) ? (4'b0001 << off) : (sz == 1) ? ((off >= 2) ? 4'b1100 : 4'b0011) : 4'b1111;
                e_wdata = (sz == 0) ? {4{rs2[7:0]}} : (sz == 1) ? {2{rs2[15:0]}} : rs2;
            end
            chk("run", run, e_run);
            chk("req_valid", dbus.req_valid, e_req);
            chk("rdata", rdata, e_rdata);
            chk("bus_err", bus_err, e_err);
            chk("ld_misalign", ld_mis, mem_valid && ld && mis);
            chk("st_misalign", st_mis, mem_valid && st && mis);
            if (e_req) begin
                chk("addr", dbus.addr, e_addr);
                chk("wen", dbus.wen, e_wen);
                chk("wstrb", dbus.wstrb, e_wstrb);
                chk("wdata", dbus.wdata, e_wdata);
            end
            // advance the model across the coming clock edge
            if (m_res) begin
                if (wb_ready || mem_flush) m_res = 0;
            end else if (m_out) begin
                if (dbus.rsp_valid) begin
                    m_out = 0;
                    if (m_keep && !mem_flush) begin
                        m_res = 1; r_data = dbus.rsp_rdata; r_err = dbus.rsp_err;
                    end
                end else if (mem_flush) begin
                    m_keep = 0;
                end
            end else if (m_pend) begin
                if (dbus.req_ready) begin
                    m_pend = 0; m_out = 1; m_keep = !mem_flush;
                end else if (mem_flush) begin
                    m_pend = 0;
                end
            end else if (acc) begin
                p_addr = e_addr; p_wen = e_wen; p_wstrb = e_wstrb; p_wdata = e_wdata;
                p_size = sz; p_off = off; p_uns = info[4];
                if (dbus.req_ready) begin m_out = 1; m_keep = 1; end
                else m_pend = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        dbus.req_ready = 1'b0; dbus.rsp_valid = 1'b0;
        dbus.rsp_rdata = '0;   dbus.rsp_err   = 1'b0;
    endtask

    initial begin
        bit          bus_busy, acc_seen, rsp_seen, adv_seen;
        int          delay;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_run", run, 1);
        chk("reset_req_valid", dbus.req_valid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_flags", {ld_mis, st_mis, bus_err}, 0);

        // LB 0x1003, zero-wait, sign-extended 0x80
        step(); mem_valid = 1; info = 5'b00001; alu = 32'h1003; dbus.req_ready = 1; wb_ready = 1;
        @(negedge clk); chk("lb_run_c0", run, 0); chk("lb_addr", dbus.addr, 32'h1000);
        step(); dbus.req_ready = 0; dbus.rsp_valid = 1; dbus.rsp_rdata = 32'h80FF_FF11;
        @(negedge clk); chk("lb_run_c1", run, 0);
        step(); dbus.rsp_valid = 0;
        @(negedge clk); chk("lb_run_c2", run, 1); chk("lb_rdata", rdata, 32'hFFFF_FF80);
        step(); mem_valid = 0;
        @(negedge clk); chk("lb_idle_rdata", rdata, 0);

        // SH 0x2002
        step(); mem_valid = 1; info = 5'b00110; alu = 32'h2002; rs2 = 32'h1234_ABCD; dbus.req_ready = 1;
        @(negedge clk);
        chk("sh_addr", dbus.addr, 32'h2000); chk("sh_wstrb", dbus.wstrb, 4'b1100);
        chk("sh_wdata", dbus.wdata, 32'hABCD_ABCD); chk("sh_wen", dbus.wen, 1);
        step(); dbus.req_ready = 0; dbus.rsp_valid = 1; dbus.rsp_rdata = 32'h0;
        step(); dbus.rsp_valid = 0;
        @(negedge clk); chk("sh_done_run", run, 1);
        step(); mem_valid = 0;

        // LW 0x3001 misaligned
        step(); mem_valid = 1; info = 5'b01001; alu = 32'h3001;
        repeat (2) begin
            @(negedge clk);
            chk("lw_mis_flag", ld_mis, 1); chk("lw_mis_req", dbus.req_valid, 0); chk("lw_mis_run", run, 1);
            step();
        end
        mem_valid = 0;

        // LW stalled by req_ready, upstream address moves, then withdrawn by flush
        step(); mem_valid = 1; info = 5'b01001; alu = 32'h4000; dbus.req_ready = 0;
        @(negedge clk); chk("req_hold_c0", dbus.addr, 32'h4000);
        step(); alu = 32'h5554;
        @(negedge clk); chk("req_hold_c1", dbus.addr, 32'h4000);
        step(); alu = 32'h9998; mem_flush = 1;
        @(negedge clk); chk("req_hold_c2", dbus.addr, 32'h4000); chk("req_flush_valid", dbus.req_valid, 1);
        step(); mem_flush = 0; mem_valid = 0;
        @(negedge clk); chk("req_withdrawn", dbus.req_valid, 0); chk("req_idle_run", run, 1);

        // LHU accepted, flushed while waiting, error response discarded
        step(); mem_valid = 1; info = 5'b10101; alu = 32'h6002; dbus.req_ready = 1;
        step(); dbus.req_ready = 0; mem_flush = 1;
        @(negedge clk); chk("drain_run_rsp", run, 0);
        step(); mem_flush = 0; mem_valid = 0;
        repeat (3) begin @(negedge clk); chk("drain_run", run, 0); step(); end
        dbus.rsp_valid = 1; dbus.rsp_err = 1; dbus.rsp_rdata = 32'h1111_1111;
        @(negedge clk); chk("drain_err_hidden", bus_err, 0);
        step(); dbus.rsp_valid = 0; dbus.rsp_err = 0;
        @(negedge clk); chk("drain_done_run", run, 1); chk("drain_done_err", bus_err, 0);

        // LW held in DONE while WB stalls
        step(); mem_valid = 1; info = 5'b01001; alu = 32'h7000; dbus.req_ready = 1; wb_ready = 0;
        step(); dbus.req_ready = 0; dbus.rsp_valid = 1; dbus.rsp_rdata = 32'hDEAD_BEEF;
        step(); dbus.rsp_valid = 0; dbus.req_ready = 1;
        repeat (2) begin
            @(negedge clk); chk("done_hold_rdata", rdata, 32'hDEAD_BEEF); chk("done_no_req", dbus.req_valid, 0);
            step();
        end
        wb_ready = 1;
        @(negedge clk); chk("done_release_rdata", rdata, 32'hDEAD_BEEF);
        step(); mem_valid = 0; dbus.req_ready = 0;
        @(negedge clk); chk("after_done_rdata", rdata, 0);

        // randomized traffic
        bus_busy = 0; delay = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc_seen = dbus.req_valid && dbus.req_ready;
            rsp_seen = dbus.rsp_valid && bus_busy;
            adv_seen = run && wb_ready;
            @(posedge clk);
            #1;
            if (cyc == 1500 || cyc == 1501) begin
                rst = 1; bus_busy = 0; bus_idle(); continue;
            end
            rst = 0;
            if (rsp_seen) bus_busy = 0;
            if (acc_seen) begin
                chk("one_outstanding", bus_busy, 0);
                bus_busy = 1; delay = $urandom_range(0, 4);
            end else if (bus_busy && delay > 0) begin
                delay--;
            end
            dbus.req_ready = ($urandom_range(0, 2) != 0);
            dbus.rsp_rdata = $urandom;
            dbus.rsp_err   = ($urandom_range(0, 5) == 0);
            dbus.rsp_valid = bus_busy ? (delay == 0) : ($urandom_range(0, 7) == 0);
            if (adv_seen || mem_flush || $urandom_range(0, 5) == 0) begin
                int kind;
                kind      = $urandom_range(0, 2);
                mem_valid = ($urandom_range(0, 4) != 0);
                info      = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                             kind == 1, kind == 0};
                alu       = $urandom;
                rs2       = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                alu = $urandom;
            end
            mem_flush = ($urandom_range(0, 11) == 0);
            wb_ready  = ($urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
